// File: rtl/data_mem_responder_if.sv
// Load/store request and response bundle between the datapath (master) and the data memory
// responder (slave).
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency, byte-addressed little-endian data memory answering one load/store at a time.
// Misaligned or out-of-range requests are answered one cycle after acceptance with resp_err.
module data_mem_responder #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned LATENCY = 2
) (
    input logic                 clk,
    input logic                 rst,
    data_mem_responder_if.slave mem_if
);
    localparam int unsigned Words = 1 << ADDR_W;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, unsigned_q;
    logic [63:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [63:0] mem_q [Words];

    logic              capture, fire, wr_en, err, misalign;
    logic              cur_write, cur_unsigned;
    logic [63:0]       cur_addr, cur_wdata;
    logic [1:0]        cur_size;
    logic [2:0]        lane;
    logic [ADDR_W-1:0] widx;
    logic [63:0]       word, shifted, ext, wdata_sh, wr_word;
    logic [7:0]        size_mask, byte_en;

    // In IDLE the decision is made straight from the inputs; later states use the capture.
    always_comb begin
        cur_write    = (state_q == StIdle) ? mem_if.req_write    : write_q;
        cur_addr     = (state_q == StIdle) ? mem_if.req_addr     : addr_q;
        cur_size     = (state_q == StIdle) ? mem_if.req_size     : size_q;
        cur_unsigned = (state_q == StIdle) ? mem_if.req_unsigned : unsigned_q;
        cur_wdata    = (state_q == StIdle) ? mem_if.req_wdata    : wdata_q;
    end

    always_comb begin
        lane = cur_addr[2:0];
        widx = cur_addr[ADDR_W+2:3];
        unique case (cur_size)
            2'd0:    begin misalign = 1'b0;           size_mask = 8'h01; end
            2'd1:    begin misalign = cur_addr[0];    size_mask = 8'h03; end
            2'd2:    begin misalign = |cur_addr[1:0]; size_mask = 8'h0F; end
            default: begin misalign = |cur_addr[2:0]; size_mask = 8'hFF; end
        endcase
        err = misalign | (|cur_addr[63:ADDR_W+3]);

        word    = mem_q[widx];
        shifted = word >> {lane, 3'b000};
        unique case (cur_size)
            2'd0:    ext = {{56{~cur_unsigned & shifted[7]}},  shifted[7:0]};
            2'd1:    ext = {{48{~cur_unsigned & shifted[15]}}, shifted[15:0]};
            2'd2:    ext = {{32{~cur_unsigned & shifted[31]}}, shifted[31:0]};
            default: ext = shifted;
        endcase

        byte_en  = size_mask << lane;
        wdata_sh = cur_wdata << {lane, 3'b000};
        wr_word  = word;
        for (int b = 0; b < 8; b++) begin
            if (byte_en[b]) wr_word[b*8 +: 8] = wdata_sh[b*8 +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        fire    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_if.req_valid) begin
                    capture = 1'b1;
                    if (err || LATENCY == 1) begin
                        state_d = StResp;
                        fire    = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                    fire    = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        wr_en   = fire & cur_write & ~err;
        err_d   = fire & err;
        rdata_d = (fire && !err && !cur_write) ? ext : 64'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < Words; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (capture) begin
                write_q    <= mem_if.req_write;
                addr_q     <= mem_if.req_addr;
                size_q     <= mem_if.req_size;
                unsigned_q <= mem_if.req_unsigned;
                wdata_q    <= mem_if.req_wdata;
            end
            if (wr_en) mem_q[widx] <= wr_word;
        end
    end

    assign mem_if.req_ready  = (state_q == StIdle);
    assign mem_if.resp_valid = (state_q == StResp);
    assign mem_if.resp_rdata = rdata_q;
    assign mem_if.resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (ADDR_W=6, LATENCY=2) with hand-computed expectations.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;

    data_mem_responder_if mem_if ();

    data_mem_responder #(.ADDR_W(6), .LATENCY(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .mem_if (mem_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request, then scramble the inputs to show they are ignored after acceptance.
    task automatic xact(input logic w, input logic [63:0] addr, input logic [1:0] size,
                        input logic uns, input logic [63:0] wdata,
                        output logic [63:0] rdata, output logic err, output int lat);
        int n;
        @(negedge clk);
        mem_if.req_valid    = 1'b1;
        mem_if.req_write    = w;
        mem_if.req_addr     = addr;
        mem_if.req_size     = size;
        mem_if.req_unsigned = uns;
        mem_if.req_wdata    = wdata;
        n = 0;
        while (!mem_if.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        mem_if.req_valid    = 1'b0;
        mem_if.req_write    = ~w;
        mem_if.req_addr     = ~addr;
        mem_if.req_size     = ~size;
        mem_if.req_unsigned = ~uns;
        mem_if.req_wdata    = ~wdata;
        lat   = 0;
        rdata = 'x;
        err   = 1'bx;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (mem_if.resp_valid) begin
                rdata = mem_if.resp_rdata;
                err   = mem_if.resp_err;
                break;
            end
        end
        @(negedge clk);
        check_eq("pulse_end", {mem_if.resp_valid, mem_if.resp_err, mem_if.resp_rdata}, '0);
    endtask

    logic [63:0] rd;
    logic        er;
    int          lat;
    logic [6:0]  ready_seq;
    int          pulses;

    initial begin
        mem_if.req_valid    = 1'b0;
        mem_if.req_write    = 1'b0;
        mem_if.req_addr     = '0;
        mem_if.req_size     = '0;
        mem_if.req_unsigned = 1'b0;
        mem_if.req_wdata    = '0;
        #1;
        check_eq("rst_ready", 64'(mem_if.req_ready), 64'd1);
        check_eq("rst_resp", {mem_if.resp_valid, mem_if.resp_err, mem_if.resp_rdata}, '0);
        #20 rst = 1'b1;

        xact(1'b1, 64'h10, 2'd3, 1'b0, 64'h8877665544332211, rd, er, lat);
        check_eq("sd_lat", 64'(lat), 64'd2);
        check_eq("sd_err", 64'(er), 64'd0);
        check_eq("sd_rdata", rd, 64'd0);
        xact(1'b0, 64'h10, 2'd3, 1'b0, '0, rd, er, lat);
        check_eq("ld_lat", 64'(lat), 64'd2);
        check_eq("ld_data", rd, 64'h8877665544332211);
        xact(1'b0, 64'h17, 2'd0, 1'b0, '0, rd, er, lat);
        check_eq("lb_s", rd, 64'hFFFFFFFFFFFFFF88);
        xact(1'b0, 64'h17, 2'd0, 1'b1, '0, rd, er, lat);
        check_eq("lbu", rd, 64'h0000000000000088);

        xact(1'b1, 64'h12, 2'd1, 1'b0, 64'h000000000000BEEF, rd, er, lat);
        check_eq("sh_err", 64'(er), 64'd0);
        xact(1'b0, 64'h10, 2'd2, 1'b0, '0, rd, er, lat);
        check_eq("lw_s", rd, 64'hFFFFFFFFBEEF2211);
        xact(1'b0, 64'h10, 2'd3, 1'b0, '0, rd, er, lat);
        check_eq("ld_merge", rd, 64'h88776655BEEF2211);
        xact(1'b0, 64'h14, 2'd2, 1'b1, '0, rd, er, lat);
        check_eq("lwu", rd, 64'h0000000088776655);
        xact(1'b0, 64'h16, 2'd1, 1'b0, '0, rd, er, lat);
        check_eq("lh_s", rd, 64'hFFFFFFFFFFFF8877);
        xact(1'b1, 64'h11, 2'd0, 1'b0, 64'hFFFFFFFFFFFFFF7A, rd, er, lat);
        xact(1'b0, 64'h10, 2'd3, 1'b0, '0, rd, er, lat);
        check_eq("sb_merge", rd, 64'h88776655BEEF7A11);

        xact(1'b0, 64'h0E, 2'd2, 1'b0, '0, rd, er, lat);
        check_eq("mis_lat", 64'(lat), 64'd1);
        check_eq("mis_err", 64'(er), 64'd1);
        check_eq("mis_rdata", rd, 64'd0);
        xact(1'b1, 64'h200, 2'd3, 1'b0, 64'hFFFFFFFFFFFFFFFF, rd, er, lat);
        check_eq("oor_lat", 64'(lat), 64'd1);
        check_eq("oor_err", 64'(er), 64'd1);
        check_eq("oor_rdata", rd, 64'd0);
        xact(1'b0, 64'h0, 2'd3, 1'b0, '0, rd, er, lat);
        check_eq("oor_w0", rd, 64'd0);
        xact(1'b0, 64'h10, 2'd3, 1'b0, '0, rd, er, lat);
        check_eq("oor_w2", rd, 64'h88776655BEEF7A11);

        // Back-to-back: hold req_valid high for three loads.
        @(negedge clk);
        mem_if.req_valid    = 1'b1;
        mem_if.req_write    = 1'b0;
        mem_if.req_addr     = 64'h10;
        mem_if.req_size     = 2'd3;
        mem_if.req_unsigned = 1'b0;
        pulses              = 0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            ready_seq[i] = mem_if.req_ready;
            if (mem_if.resp_valid) pulses++;
        end
        @(posedge clk);
        #1 mem_if.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_if.resp_valid) pulses++;
        end
        check_eq("b2b_ready", 64'(ready_seq), 64'b1001001);
        check_eq("b2b_pulses", 64'(pulses), 64'd3);

        // Reset during WAIT abandons the store.
        @(negedge clk);
        mem_if.req_valid = 1'b1;
        mem_if.req_write = 1'b1;
        mem_if.req_addr  = 64'h40;
        mem_if.req_size  = 2'd3;
        mem_if.req_wdata = 64'h5555AAAA5555AAAA;
        @(posedge clk);
        #1 mem_if.req_valid = 1'b0;
        @(negedge clk);
        check_eq("wait_ready", 64'(mem_if.req_ready), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_ready", 64'(mem_if.req_ready), 64'd1);
        check_eq("mid_rst_resp", {mem_if.resp_valid, mem_if.resp_err, mem_if.resp_rdata}, '0);
        @(negedge clk);
        rst = 1'b1;
        xact(1'b0, 64'h40, 2'd3, 1'b0, '0, rd, er, lat);
        check_eq("rst_nowrite", rd, 64'd0);
        xact(1'b0, 64'h10, 2'd3, 1'b0, '0, rd, er, lat);
        check_eq("rst_cleared", rd, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
